// File: rtl/core_issue_ctrl.sv
// Issue scheduler: register scoreboard, RAW/WAW/structural hazard checks, stall/flush to decode,
// multiplier and single-outstanding load/store sequencing. Optional stats counters: ISSUE_CTRL_STATS_EN.
module core_issue_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int MUL_LAT  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic [REG_W-1:0]    dec_ra,
    input  logic [REG_W-1:0]    dec_rb,
    input  logic [REG_W-1:0]    dec_rd,
    input  logic                dec_uses_ra,
    input  logic                dec_uses_rb,
    input  logic                dec_writeback,
    input  logic                dec_mul,
    input  logic                dec_ldst,
    input  logic                dec_load,
    input  logic                branch_taken,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic                mem_ack,
    output logic                stall,
    output logic                flush,
    output logic                issue,
    output logic                mul_start,
    output logic                mul_done,
    output logic                mem_req,
    output logic [NUM_REGS-1:0] pending
`ifdef ISSUE_CTRL_STATS_EN
    ,
    output logic [15:0]         stall_raw_cnt,
    output logic [15:0]         stall_struct_cnt,
    output logic [15:0]         flush_cnt
`endif
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    // The issue cycle counts as the first of MUL_LAT, so done lands MUL_LAT-1 cycles later.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {S_IDLE, S_REQ} mem_state_t;

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_mul_cnt;
    logic [REG_W-1:0]    r_mul_rd;
    mem_state_t          r_mem_state;
    logic [REG_W-1:0]    r_mem_rd;
    logic                r_mem_load;
    logic                r_mem_req;

    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_eff;
    logic                w_raw, w_waw, w_mul_struct, w_mem_struct;

    always_comb begin
        w_clr = '0;
        if (wb_valid)
            w_clr[wb_rd] = 1'b1;
        if (r_mul_cnt == CNT_ONE)
            w_clr[r_mul_rd] = 1'b1;
        if (r_mem_state == S_REQ && mem_ack && r_mem_load)
            w_clr[r_mem_rd] = 1'b1;
        w_clr[0] = 1'b0;
    end

    assign w_eff        = r_pending & ~w_clr;
    assign w_raw        = (dec_uses_ra & w_eff[dec_ra]) | (dec_uses_rb & w_eff[dec_rb]);
    assign w_waw        = dec_writeback & w_eff[dec_rd];
    assign w_mul_struct = dec_mul & (r_mul_cnt > CNT_ONE);
    assign w_mem_struct = dec_ldst & (r_mem_state != S_IDLE) & ~mem_ack;

    assign flush     = branch_taken;
    assign stall     = dec_valid & ~flush & (w_raw | w_waw | w_mul_struct | w_mem_struct);
    assign issue     = dec_valid & ~stall & ~flush;
    assign mul_start = issue & dec_mul;
    assign mul_done  = (r_mul_cnt == CNT_ONE);
    assign mem_req   = r_mem_req;
    assign pending   = r_pending;

    always_comb begin
        w_set = '0;
        if (issue && dec_writeback && dec_rd != '0)
            w_set[dec_rd] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-cycle set/clear on one register leaves it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_cnt <= '0;
            r_mul_rd  <= '0;
        end else if (mul_start) begin
            r_mul_cnt <= MUL_LOAD;
            r_mul_rd  <= dec_rd;
        end else if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_state <= S_IDLE;
            r_mem_rd    <= '0;
            r_mem_load  <= 1'b0;
            r_mem_req   <= 1'b0;
        end else begin
            case (r_mem_state)
                S_IDLE: begin
                    if (issue && dec_ldst) begin
                        r_mem_state <= S_REQ;
                        r_mem_rd    <= dec_rd;
                        r_mem_load  <= dec_load;
                        r_mem_req   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (issue && dec_ldst) begin
                            r_mem_rd   <= dec_rd;
                            r_mem_load <= dec_load;
                        end else begin
                            r_mem_state <= S_IDLE;
                            r_mem_req   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_mem_state <= S_IDLE;
                    r_mem_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ISSUE_CTRL_STATS_EN
    logic w_cnt_raw, w_cnt_struct;
    // A cycle with both raw and structural causes is attributed to raw only.
    assign w_cnt_raw    = dec_valid & ~flush & w_raw;
    assign w_cnt_struct = dec_valid & ~flush & ~w_raw & (w_mul_struct | w_mem_struct);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_raw_cnt    <= '0;
            stall_struct_cnt <= '0;
            flush_cnt        <= '0;
        end else begin
            if (w_cnt_raw && stall_raw_cnt != 16'hFFFF)
                stall_raw_cnt <= stall_raw_cnt + 16'd1;
            if (w_cnt_struct && stall_struct_cnt != 16'hFFFF)
                stall_struct_cnt <= stall_struct_cnt + 16'd1;
            if (flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Bench for core_issue_ctrl: directed per-cycle vector table, reset-in-flight sequence,
// then random stimulus against a cycle-count-based reference model.
module tb_core_issue_ctrl;
    localparam int NR = 8;
    localparam int RW = 3;
    localparam int ML = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dec_valid, dec_uses_ra, dec_uses_rb, dec_writeback, dec_mul, dec_ldst, dec_load;
    logic [RW-1:0] dec_ra, dec_rb, dec_rd, wb_rd;
    logic branch_taken, wb_valid, mem_ack;
    logic stall, flush, issue, mul_start, mul_done, mem_req;
    logic [NR-1:0] pending;

    core_issue_ctrl #(.NUM_REGS(NR), .REG_W(RW), .MUL_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_rd(dec_rd),
        .dec_uses_ra(dec_uses_ra), .dec_uses_rb(dec_uses_rb), .dec_writeback(dec_writeback),
        .dec_mul(dec_mul), .dec_ldst(dec_ldst), .dec_load(dec_load),
        .branch_taken(branch_taken), .wb_valid(wb_valid), .wb_rd(wb_rd), .mem_ack(mem_ack),
        .stall(stall), .flush(flush), .issue(issue), .mul_start(mul_start),
        .mul_done(mul_done), .mem_req(mem_req), .pending(pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic v; logic [2:0] ra, rb, rd;
        logic ua, ub, wbk, mul, ldst, ld, br, wbv; logic [2:0] wbrd; logic ack;
        logic e_stall, e_flush, e_issue, e_ms, e_md, e_mreq; logic [7:0] e_pend;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        dec_valid = t.v; dec_ra = t.ra; dec_rb = t.rb; dec_rd = t.rd;
        dec_uses_ra = t.ua; dec_uses_rb = t.ub; dec_writeback = t.wbk;
        dec_mul = t.mul; dec_ldst = t.ldst; dec_load = t.ld;
        branch_taken = t.br; wb_valid = t.wbv; wb_rd = t.wbrd; mem_ack = t.ack;
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00};
        drive(z);
    endtask

    task automatic chk_outs(input string tag, input logic st, input logic fl, input logic is,
                            input logic ms, input logic md, input logic mr, input logic [7:0] pd);
        chk({tag, ".stall"},     stall,     st);
        chk({tag, ".flush"},     flush,     fl);
        chk({tag, ".issue"},     issue,     is);
        chk({tag, ".mul_start"}, mul_start, ms);
        chk({tag, ".mul_done"},  mul_done,  md);
        chk({tag, ".mem_req"},   mem_req,   mr);
        chk({tag, ".pending"},   pending,   pd);
    endtask

    // Reference model state: multiplier tracked by the absolute cycle its result lands.
    logic [7:0] m_pend;
    int         m_cyc, m_mul_at;
    logic [2:0] m_mul_rd, m_mem_rd;
    bit         m_mem_busy, m_mem_ld;

    initial begin
        // fields: v ra rb rd ua ub wbk mul ldst ld br wbv wbrd ack | stall flush issue ms md mreq pend
        tbl[0]  = '{1,0,0,3, 0,0,1,0,0,0,0,0,0,0, 0,0,1,0,0,0,8'h00}; // ALU rd=3
        tbl[1]  = '{1,3,0,0, 1,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,8'h08}; // consumer of r3
        tbl[2]  = '{1,3,0,0, 1,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,8'h08};
        tbl[3]  = '{1,3,0,0, 1,0,0,0,0,0,0,1,3,0, 0,0,1,0,0,0,8'h08}; // wb r3 same cycle
        tbl[4]  = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00};
        tbl[5]  = '{1,0,0,5, 0,0,1,1,0,0,0,0,0,0, 0,0,1,1,0,0,8'h00}; // mul rd=5
        tbl[6]  = '{1,0,0,6, 0,0,1,1,0,0,0,0,0,0, 1,0,0,0,0,0,8'h20}; // 2nd mul too early
        tbl[7]  = '{1,0,0,6, 0,0,1,1,0,0,0,0,0,0, 0,0,1,1,1,0,8'h20}; // back-to-back
        tbl[8]  = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,8'h40};
        tbl[9]  = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,8'h40};
        tbl[10] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00};
        tbl[11] = '{1,0,0,2, 0,0,1,0,1,1,0,0,0,0, 0,0,1,0,0,0,8'h00}; // load rd=2
        tbl[12] = '{1,2,0,0, 1,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1,8'h04}; // uses r2
        tbl[13] = '{1,0,0,0, 0,0,0,0,1,0,0,0,0,0, 1,0,0,0,0,1,8'h04}; // store, port busy
        tbl[14] = '{1,2,0,0, 1,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1,8'h04};
        tbl[15] = '{1,0,0,0, 0,0,0,0,1,0,0,0,0,0, 1,0,0,0,0,1,8'h04};
        tbl[16] = '{1,2,0,4, 1,0,1,0,1,1,0,0,0,1, 0,0,1,0,0,1,8'h04}; // ack + new load on r2
        tbl[17] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,8'h10};
        tbl[18] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,1,8'h10};
        tbl[19] = '{1,0,0,0, 0,0,0,0,1,0,0,0,0,0, 0,0,1,0,0,0,8'h00}; // store
        tbl[20] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,1,8'h00};
        tbl[21] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00};
        tbl[22] = '{1,0,0,1, 0,0,1,1,0,0,0,0,0,0, 0,0,1,1,0,0,8'h00}; // mul rd=1
        tbl[23] = '{1,1,0,0, 1,0,0,0,0,0,1,0,0,0, 0,1,0,0,0,0,8'h02}; // flush over stalled dep
        tbl[24] = '{1,1,0,0, 1,0,0,0,0,0,1,0,0,0, 0,1,0,0,1,0,8'h02};
        tbl[25] = '{1,1,0,0, 1,0,0,0,0,0,0,0,0,0, 0,0,1,0,0,0,8'h00};
        tbl[26] = '{0,0,0,0, 0,0,0,0,0,0,0,1,7,0, 0,0,0,0,0,0,8'h00}; // wb to idle reg
        tbl[27] = '{1,0,0,0, 0,0,1,0,0,0,0,0,0,0, 0,0,1,0,0,0,8'h00}; // rd=0 never tracked
        tbl[28] = '{1,0,0,3, 0,0,1,0,0,0,0,0,0,0, 0,0,1,0,0,0,8'h00};
        tbl[29] = '{1,0,0,3, 0,0,1,0,0,0,0,1,3,0, 0,0,1,0,0,0,8'h08}; // set beats clear
        tbl[30] = '{1,0,0,3, 0,0,1,0,0,0,0,0,0,0, 1,0,0,0,0,0,8'h08}; // WAW
        tbl[31] = '{0,0,0,0, 0,0,0,0,0,0,0,1,3,0, 0,0,0,0,0,0,8'h08};
        tbl[32] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00};

        idle_inputs();
        repeat (2) @(negedge clk);
        #1 chk_outs("reset", 0,0,0,0,0,0,8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #1;
            chk_outs($sformatf("v%0d", i), tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_issue,
                     tbl[i].e_ms, tbl[i].e_md, tbl[i].e_mreq, tbl[i].e_pend);
            @(negedge clk);
        end

        // Reset with a mul about to complete and the memory port in REQ.
        begin
            vec_t m, l;
            m = '{1,0,0,5, 0,0,1,1,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00};
            l = '{1,0,0,2, 0,0,1,0,1,1,0,0,0,0, 0,0,0,0,0,0,8'h00};
            drive(m); #1 chk("rst_seq.mul_issue", issue, 1'b1);
            @(negedge clk);
            drive(l); #1 chk("rst_seq.ld_issue", issue, 1'b1);
            @(negedge clk);
            idle_inputs();
            #1 chk("rst_seq.pre_done", mul_done, 1'b1);
            rst_n = 1'b0;
            #1 chk_outs("rst_mid", 0,0,0,0,0,0,8'h00);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("rst_after.mul_done", mul_done, 1'b0);
                chk("rst_after.mem_req",  mem_req,  1'b0);
                @(negedge clk);
            end
        end

        // Random phase against the reference model.
        m_pend = '0; m_cyc = 0; m_mul_at = -1; m_mul_rd = '0;
        m_mem_busy = 0; m_mem_rd = '0; m_mem_ld = 0;
        for (int n = 0; n < 600; n++) begin
            vec_t r;
            logic [7:0] clr, eff, setv;
            bit raw, waw, ms_s, mm_s, e_stall, e_flush, e_issue, e_md;
            r = '{($urandom_range(0,9) < 7), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0,3) == 0),
                  ($urandom_range(0,3) == 0), 1'($urandom), ($urandom_range(0,9) == 0),
                  ($urandom_range(0,9) < 3), 3'($urandom), ($urandom_range(0,9) < 4),
                  0,0,0,0,0,0,8'h00};
            drive(r);
            #1;
            e_md = (m_cyc == m_mul_at);
            clr = '0;
            if (r.wbv) clr[r.wbrd] = 1'b1;
            if (e_md) clr[m_mul_rd] = 1'b1;
            if (m_mem_busy && r.ack && m_mem_ld) clr[m_mem_rd] = 1'b1;
            clr[0] = 1'b0;
            eff  = m_pend & ~clr;
            raw  = (r.ua && eff[r.ra]) || (r.ub && eff[r.rb]);
            waw  = r.wbk && eff[r.rd];
            ms_s = r.mul && (m_mul_at > m_cyc);
            mm_s = r.ldst && m_mem_busy && !r.ack;
            e_flush = r.br;
            e_stall = r.v && !e_flush && (raw || waw || ms_s || mm_s);
            e_issue = r.v && !e_stall && !e_flush;
            chk_outs($sformatf("rnd%0d", n), e_stall, e_flush, e_issue, e_issue && r.mul,
                     e_md, m_mem_busy, m_pend);
            setv = '0;
            if (e_issue && r.wbk && r.rd != 0) setv[r.rd] = 1'b1;
            m_pend = eff | setv;
            if (e_issue && r.mul) begin
                m_mul_at = m_cyc + ML - 1;
                m_mul_rd = r.rd;
            end
            if (m_mem_busy && r.ack) m_mem_busy = 0;
            if (e_issue && r.ldst) begin
                m_mem_busy = 1; m_mem_rd = r.rd; m_mem_ld = r.ld;
            end
            m_cyc++;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
